// File: rtl/ewrapper_io_tx_ser.sv
// eLink transmit serializer: 9 lanes x 8 bits, 2 bits per lane per fast cycle, 4-slot frames.
// Optional build macro ETX_LANE_INVERT_EN inverts TX_EVEN/TX_ODD at the output registers.
module ewrapper_io_tx_ser (
    input  logic        CLK_IN,
    input  logic        IO_RESET,
    input  logic [71:0] DATA_FROM_DEVICE,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    output logic [8:0]  TX_EVEN,
    output logic [8:0]  TX_ODD,
    output logic        TX_FRAME,
    output logic        TX_IDLE,
    output logic [15:0] UNDERFLOW_CNT
);

`ifdef ETX_LANE_INVERT_EN
    localparam logic [8:0] LANE_POL = 9'h1FF;
`else
    localparam logic [8:0] LANE_POL = 9'h000;
`endif

    logic [1:0]  cnt_r;
    logic        full_r;
    logic [71:0] hold_r;
    logic [71:0] word_r;
    logic [8:0]  tx_even_r;
    logic [8:0]  tx_odd_r;
    logic        tx_frame_r;
    logic        tx_idle_r;
    logic [15:0] uf_cnt_r;

    logic        ready_s;
    logic        load_s;
    logic        accept_s;
    logic [1:0]  cnt_nx_s;
    logic        full_nx_s;
    logic [71:0] word_nx_s;
    logic        idle_nx_s;
    logic        uf_inc_s;

    // Per-lane bit of slot s: even takes bit 7-2s, odd takes bit 6-2s, MSB first.
    function automatic logic [8:0] slot_bits(input logic [71:0] w, input logic [1:0] s,
                                             input logic odd);
        logic [8:0] r;
        logic [7:0] b;
        logic [2:0] pos;
        pos = 3'd7 - {s, 1'b0} - {2'b00, odd};
        r   = 9'h000;
        for (int l = 0; l < 9; l++) begin
            b    = w[l*8 +: 8];
            r[l] = b[pos];
        end
        return r;
    endfunction

    assign ready_s    = ~full_r | (cnt_r == 2'd3);
    assign DATA_READY = ready_s;

    // Handshake, frame-load selection and underflow detection.
    always_comb begin
        load_s    = (cnt_r == 2'd3);
        accept_s  = DATA_VALID & ready_s;
        cnt_nx_s  = cnt_r + 2'd1;
        word_nx_s = word_r;
        idle_nx_s = tx_idle_r;
        uf_inc_s  = 1'b0;
        full_nx_s = full_r;
        if (load_s) begin
            if (full_r) begin
                word_nx_s = hold_r;
                idle_nx_s = 1'b0;
            end else begin
                word_nx_s = 72'd0;
                idle_nx_s = 1'b1;
                uf_inc_s  = ~tx_idle_r & (uf_cnt_r != 16'hFFFF);
            end
        end else begin
            word_nx_s = word_r;
            idle_nx_s = tx_idle_r;
        end
        // A same-edge accept refills the hold register the load just drained.
        if (accept_s) begin
            full_nx_s = 1'b1;
        end else if (load_s) begin
            full_nx_s = 1'b0;
        end else begin
            full_nx_s = full_r;
        end
    end

    // State and registered outputs; output slot tracks the post-edge counter.
    always_ff @(posedge CLK_IN or posedge IO_RESET) begin
        if (IO_RESET) begin
            cnt_r      <= 2'd0;
            full_r     <= 1'b0;
            hold_r     <= 72'd0;
            word_r     <= 72'd0;
            tx_even_r  <= LANE_POL;
            tx_odd_r   <= LANE_POL;
            tx_frame_r <= 1'b1;
            tx_idle_r  <= 1'b1;
            uf_cnt_r   <= 16'd0;
        end else begin
            cnt_r      <= cnt_nx_s;
            full_r     <= full_nx_s;
            hold_r     <= accept_s ? DATA_FROM_DEVICE : hold_r;
            word_r     <= word_nx_s;
            tx_even_r  <= slot_bits(word_nx_s, cnt_nx_s, 1'b0) ^ LANE_POL;
            tx_odd_r   <= slot_bits(word_nx_s, cnt_nx_s, 1'b1) ^ LANE_POL;
            tx_frame_r <= load_s;
            tx_idle_r  <= idle_nx_s;
            uf_cnt_r   <= uf_cnt_r + {15'd0, uf_inc_s};
        end
    end

    assign TX_EVEN       = tx_even_r;
    assign TX_ODD        = tx_odd_r;
    assign TX_FRAME      = tx_frame_r;
    assign TX_IDLE       = tx_idle_r;
    assign UNDERFLOW_CNT = uf_cnt_r;

endmodule

// File: tb/tb_ewrapper_io_tx_ser.sv
// Self-checking bench for ewrapper_io_tx_ser: vector table, directed sequences,
// randomized traffic against a queue-based model, and a deserializing loopback.
module tb_ewrapper_io_tx_ser;

`ifdef ETX_LANE_INVERT_EN
    localparam logic [8:0] INV = 9'h1FF;
`else
    localparam logic [8:0] INV = 9'h000;
`endif

    logic        CLK_IN = 1'b0;
    logic        IO_RESET = 1'b1;
    logic [71:0] DATA_FROM_DEVICE = 72'd0;
    logic        DATA_VALID = 1'b0;
    logic        DATA_READY;
    logic [8:0]  TX_EVEN, TX_ODD;
    logic        TX_FRAME, TX_IDLE;
    logic [15:0] UNDERFLOW_CNT;

    ewrapper_io_tx_ser dut (
        .CLK_IN(CLK_IN), .IO_RESET(IO_RESET), .DATA_FROM_DEVICE(DATA_FROM_DEVICE),
        .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .TX_EVEN(TX_EVEN),
        .TX_ODD(TX_ODD), .TX_FRAME(TX_FRAME), .TX_IDLE(TX_IDLE),
        .UNDERFLOW_CNT(UNDERFLOW_CNT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: edge count mod 4, a queue of accepted-but-unsent words.
    int          m_slot;
    logic [71:0] m_q[$];
    logic [71:0] m_cur;
    bit          m_idle;
    int          m_uf;

    // Loopback receiver state
    logic [71:0] sent_q[$];
    logic [71:0] rx_word;
    int          rx_slot;
    bit          rx_active;
    int          rx_count;
    int          data_frames, idle_frames, gap_frames;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        IO_RESET = 1'b1;
        DATA_VALID = 1'b0;
        DATA_FROM_DEVICE = 72'd0;
        repeat (3) @(posedge CLK_IN);
        #1;
        chk("rst_even", TX_EVEN, INV);
        chk("rst_odd", TX_ODD, INV);
        chk("rst_frame", TX_FRAME, 1'b1);
        chk("rst_idle", TX_IDLE, 1'b1);
        chk("rst_uf", UNDERFLOW_CNT, 16'd0);
        chk("rst_ready", DATA_READY, 1'b1);
        IO_RESET = 1'b0;
        m_slot = 0; m_q.delete(); m_cur = 72'd0; m_idle = 1'b1; m_uf = 0;
        sent_q.delete(); rx_active = 1'b0; rx_slot = 0;
        data_frames = 0; idle_frames = 0; gap_frames = 0;
    endtask

    // One clock edge: drive inputs, advance the model, compare, feed the receiver.
    task automatic cycle(input logic v, input logic [71:0] d);
        logic       exp_ready;
        logic [8:0] exp_even, exp_odd;
        DATA_VALID = v;
        DATA_FROM_DEVICE = d;
        exp_ready = (m_q.size() == 0) || (m_slot == 3);
        chk("ready", DATA_READY, exp_ready);
        if (m_slot == 3) begin
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_idle = 1'b0;
            end else begin
                if (!m_idle && m_uf < 65535) m_uf++;
                m_cur = 72'd0;
                m_idle = 1'b1;
            end
        end
        if (v && exp_ready) begin
            m_q.push_back(d);
            sent_q.push_back(d);
        end
        m_slot = (m_slot + 1) % 4;
        @(posedge CLK_IN);
        #1;
        for (int l = 0; l < 9; l++) begin
            exp_even[l] = m_cur[8*l + 7 - 2*m_slot] ^ INV[l];
            exp_odd[l]  = m_cur[8*l + 6 - 2*m_slot] ^ INV[l];
        end
        chk("even", TX_EVEN, exp_even);
        chk("odd", TX_ODD, exp_odd);
        chk("frame", TX_FRAME, m_slot == 0);
        chk("idle", TX_IDLE, m_idle);
        chk("underflow", UNDERFLOW_CNT, m_uf);
        if (TX_FRAME) begin
            rx_slot = 0;
            rx_active = !TX_IDLE;
            rx_word = 72'd0;
            if (TX_IDLE) begin
                idle_frames++;
                if (data_frames > 0) gap_frames++;
            end else begin
                data_frames++;
            end
        end
        if (rx_active) begin
            for (int l = 0; l < 9; l++) begin
                rx_word[8*l + 7 - 2*rx_slot] = TX_EVEN[l] ^ INV[l];
                rx_word[8*l + 6 - 2*rx_slot] = TX_ODD[l] ^ INV[l];
            end
            rx_slot++;
            if (rx_slot == 4) begin
                rx_active = 1'b0;
                rx_count++;
                if (sent_q.size() == 0) chk("loopback_extra", rx_word, 72'hX);
                else chk("loopback", rx_word, sent_q.pop_front());
            end
        end
    endtask

    typedef struct {
        logic        v;
        logic [71:0] d;
        logic [8:0]  ev;
        logic [8:0]  od;
        logic        fr;
        logic        id;
        logic [15:0] uf;
    } vec_t;

    vec_t        tbl[9];
    logic [71:0] w1;
    logic [95:0] rnd;
    logic        rdy;
    int          k;

    initial begin
        w1 = 72'h80_40_20_10_08_04_02_01_FF;
        tbl[0] = '{1'b0, 72'hDEAD, 9'h000, 9'h000, 1'b0, 1'b1, 16'd0};
        tbl[1] = '{1'b0, 72'hBEEF, 9'h000, 9'h000, 1'b0, 1'b1, 16'd0};
        tbl[2] = '{1'b1, w1,       9'h000, 9'h000, 1'b0, 1'b1, 16'd0};
        tbl[3] = '{1'b0, 72'h1234, 9'h101, 9'h081, 1'b1, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 72'h5678, 9'h041, 9'h021, 1'b0, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 72'h9ABC, 9'h011, 9'h009, 1'b0, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 72'hDEF0, 9'h005, 9'h003, 1'b0, 1'b0, 16'd0};
        tbl[7] = '{1'b0, 72'h0F0F, 9'h000, 9'h000, 1'b1, 1'b1, 16'd1};
        tbl[8] = '{1'b0, 72'hF0F0, 9'h000, 9'h000, 1'b0, 1'b1, 16'd1};
        rx_count = 0;

        // Idle after reset plus single word accepted at pre-edge slot 2
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            chk("tbl_even", TX_EVEN, tbl[i].ev ^ INV);
            chk("tbl_odd", TX_ODD, tbl[i].od ^ INV);
            chk("tbl_frame", TX_FRAME, tbl[i].fr);
            chk("tbl_idle", TX_IDLE, tbl[i].id);
            chk("tbl_uf", UNDERFLOW_CNT, tbl[i].uf);
        end

        // Back-to-back stream of words 1..8
        do_reset();
        k = 1;
        for (int n = 0; n < 35; n++) begin
            rdy = DATA_READY;
            cycle(k <= 8, 72'(k));
            if (k <= 8 && rdy) k++;
        end
        chk("stream_frames", data_frames, 8);
        chk("stream_gaps", gap_frames, 0);
        chk("stream_uf", UNDERFLOW_CNT, 16'd0);

        // Underflow: one word, three idle frames, one word
        do_reset();
        for (int n = 0; n <= 22; n++) begin
            rnd = {$urandom, $urandom, $urandom};
            cycle(n == 2 || n == 18, rnd[71:0]);
        end
        chk("uflow_cnt", UNDERFLOW_CNT, 16'd1);
        chk("uflow_idle_frames", gap_frames, 3);
        chk("uflow_data_frames", data_frames, 2);

        // Asynchronous reset in slot 2 of a data frame with a second word held
        do_reset();
        for (int n = 0; n < 6; n++) cycle(n == 2 || n == 4, 72'hA5A5_5A5A_0000 + 72'(n));
        #2 IO_RESET = 1'b1;
        #1;
        chk("mid_even", TX_EVEN, INV);
        chk("mid_odd", TX_ODD, INV);
        chk("mid_frame", TX_FRAME, 1'b1);
        chk("mid_idle", TX_IDLE, 1'b1);
        chk("mid_uf", UNDERFLOW_CNT, 16'd0);
        chk("mid_ready", DATA_READY, 1'b1);
        do_reset();
        for (int n = 0; n < 16; n++) cycle(1'b0, 72'd0);
        chk("mid_no_data", data_frames, 0);

        // Randomized traffic with loopback
        do_reset();
        rx_count = 0;
        for (int n = 0; n < 1600; n++) begin
            rnd = {$urandom, $urandom, $urandom};
            cycle(((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
                  rnd[71:0]);
        end
        for (int n = 0; n < 12; n++) cycle(1'b0, 72'd0);
        chk("loop_drained", sent_q.size(), 0);
        chk("loop_enough", rx_count >= 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ewrapper_io_tx_ser.md
# ewrapper_io_tx_ser

Fast-clock transmit serializer for the eLink wrapper, mirror of the receive deserializer. Accepts 72-bit words (9 lanes × 8 bits) from the device side through a valid/ready handshake, buffers one word, and emits 2 bits per lane per fast-clock cycle as even/odd pairs for the downstream ODDR stage. A frame of 4 fast cycles carries one word. Bit order matches the receiver, so words cross a TX→RX loop unchanged. Inserts an all-zero idle word when no data is available, and counts data-underflow gaps.

## Interface
- No parameters. Lane count is fixed at 9 and slots per word at 4.
- CLK_IN  in  1  fast transmit clock (single clock domain).
- IO_RESET  in  1  reset, asynchronous and active-high.
- DATA_FROM_DEVICE  in  72  word to send; lane L = bits [8L+7:8L].
- DATA_VALID  in  1  word present.
- DATA_READY  out  1  block can accept a word this cycle.
- TX_EVEN  out  9  per-lane bit for the first half-cycle (ODDR D1).
- TX_ODD  out  9  per-lane bit for the second half-cycle (ODDR D2).
- TX_FRAME  out  1  high during slot 0 of each frame.
- TX_IDLE  out  1  high while the current frame carries an idle word.
- UNDERFLOW_CNT  out  16  saturating count of idle frames that directly follow a data frame.

## Operation
- Slot counter `cnt[1:0]` is free-running: it takes the sequence 0,1,2,3,0,…
- Hold register is 72 bits plus a `full` flag.
- `DATA_READY = ~full | (cnt==3)`. It is combinational from registers only and does not depend on DATA_VALID.
- Accept occurs when `DATA_VALID & DATA_READY` at an edge. At that edge the hold register takes DATA_FROM_DEVICE and `full` is set to 1.
- Frame load happens on an edge where pre-edge `cnt==3`:
  - If `full`: W ← hold, TX_IDLE ← 0, and `full` clears. If an accept happens at the same edge, `full` stays 1 and the hold register takes the new word.
  - If not `full`: W ← 72'd0 and TX_IDLE ← 1.
- Slot mapping for lane L in slot s, where b = W[8L+7:8L]:
  - TX_EVEN[L] = b[7−2s]
  - TX_ODD[L] = b[6−2s]
  - So slot 0 sends bits 7/6 and slot 3 sends bits 1/0.
- Outputs are registered. After every edge, TX_EVEN/TX_ODD show slot `cnt` of W, using the post-edge `cnt`. On a load edge, slot 0 of the new W appears on that same edge.
- TX_FRAME is registered and equals (post-edge `cnt==0`).
- UNDERFLOW_CNT increments on a load edge that loads idle when the previous W was data (TX_IDLE was 0). It saturates at 16'hFFFF and never wraps.
- Reset, including when asserted mid-frame:
  - `cnt=0`, `full=0`, W=0.
  - TX_EVEN=0, TX_ODD=0.
  - TX_FRAME=1, TX_IDLE=1, UNDERFLOW_CNT=0.
  - DATA_READY=1.
  - Any held or in-flight word is discarded.
- After reset release:
  - The first edge takes `cnt` to 1.
  - The first load edge is the 4th edge after release.

## Timing
- Accept-to-slot-0 latency is 1 to 4 edges, depending on `cnt` at the accept:
  - Accept with pre-edge `cnt==3` and hold empty: the word is held, then loaded 4 edges later. There is no bypass.
  - Accept with pre-edge `cnt==2`: loaded on the next edge.
- Throughput is one word per 4 cycles. With DATA_VALID held high, DATA_READY pulses once per frame (at `cnt==3`) after the first word fills the hold register. There are no idle gaps.
- DATA_FROM_DEVICE is sampled only on the accept edge. Changes while not accepted are ignored.
- Simultaneous accept and load at `cnt==3` is legal and loses no data.

## Configuration
- `ETX_LANE_INVERT_EN` defined: TX_EVEN and TX_ODD are inverted at the output registers. This is the E64 board polarity, and it pairs with the receiver's input inversion. The reset value is then 9'h1FF on both. The idle word is still W=0, so idle appears on the pins as all ones.
- Not defined: outputs are non-inverted. Reset value and idle are 9'h000.
- No other behaviour changes: handshake, counters, TX_FRAME and TX_IDLE are identical in both builds.

## Test plan
- Reset then idle: hold IO_RESET 3 cycles, release, with DATA_VALID=0 → TX_EVEN/TX_ODD=0, TX_IDLE=1, UNDERFLOW_CNT=0, and TX_FRAME high every 4th cycle.
- Single word: accept 72'h80_40_20_10_08_04_02_01_FF at pre-edge `cnt==2` → on the next edge TX_FRAME=1 and TX_IDLE=0. Over the following 4 edges, lane 0 gives even/odd pairs 11,11,11,11. Lane 8 (byte 0x80) gives 10,00,00,00.
- Back-to-back stream: DATA_VALID=1 with 8 sequential words 72'h1…72'h8 → 8 consecutive data frames with no idle frame, DATA_READY high only at `cnt==3` after the first fill, UNDERFLOW_CNT=0.
- Underflow: send 1 word, stop for 3 frames, then send 1 word → UNDERFLOW_CNT=1 (not 3), with TX_IDLE=1 for exactly 3 frames.
- Mid-frame reset: accept a word, assert IO_RESET at slot 2 → all outputs return to their reset values immediately (asynchronously), and the word is never transmitted after release.
- Loopback: drive TX_EVEN/TX_ODD through an ODDR model into the receive deserializer, 100 random words, with `ETX_LANE_INVERT_EN` matching the receiver build → received words equal the sent words in order.
